trap_pipe_unit: RTL and testbench

TRAP_PIPE_UNIT -- requirements
Module: trap_pipe_unit

---
 rtl/ppc_types.sv | 17 +
 rtl/trap_compare.sv | 46 ++++
 rtl/trap_pipe_unit.sv | 147 ++++++++++++++
 tb/tb_trap_pipe_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppc_types.sv
// Shared types for the PowerPC trap pipeline: TO field layout and compare-bit indices.
package ppc_types;

  localparam int TRAP_TO_LT  = 0;
  localparam int TRAP_TO_GT  = 1;
  localparam int TRAP_TO_EQ  = 2;
  localparam int TRAP_TO_LTU = 3;
  localparam int TRAP_TO_GTU = 4;
  localparam int TRAP_NUM_TO = 5;

  // TO uses ISA bit numbering: to[0] is the signed less-than condition.
  typedef struct packed {
    logic [0:TRAP_NUM_TO-1] to;
    logic                   dword;
  } trap_ctrl_t;

endpackage

// File: rtl/trap_compare.sv
// Combinational tw/td compare: five TO-gated hit bits.
// Narrow compares use the architectural low word, which is op[31:0] in this little-endian vector.
module trap_compare
  import ppc_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         op1,
  input  logic [XLEN-1:0]         op2,
  input  trap_ctrl_t              control,
  output logic [0:TRAP_NUM_TO-1]  hit
);

  logic wide;
  logic lt_s;
  logic gt_s;
  logic eq;
  logic lt_u;
  logic gt_u;

  always_comb begin
    // dword only has meaning on a 64-bit datapath
    wide = (XLEN == 64) && control.dword;
    if (wide) begin
      lt_s = $signed(op1) < $signed(op2);
      gt_s = $signed(op1) > $signed(op2);
      eq   = op1 == op2;
      lt_u = op1 < op2;
      gt_u = op1 > op2;
    end else begin
      lt_s = $signed(op1[31:0]) < $signed(op2[31:0]);
      gt_s = $signed(op1[31:0]) > $signed(op2[31:0]);
      eq   = op1[31:0] == op2[31:0];
      lt_u = op1[31:0] < op2[31:0];
      gt_u = op1[31:0] > op2[31:0];
    end

    hit              = '0;
    hit[TRAP_TO_LT]  = control.to[TRAP_TO_LT]  & lt_s;
    hit[TRAP_TO_GT]  = control.to[TRAP_TO_GT]  & gt_s;
    hit[TRAP_TO_EQ]  = control.to[TRAP_TO_EQ]  & eq;
    hit[TRAP_TO_LTU] = control.to[TRAP_TO_LTU] & lt_u;
    hit[TRAP_TO_GTU] = control.to[TRAP_TO_GTU] & gt_u;
  end

endmodule

// File: rtl/trap_pipe_unit.sv
// Trap-condition pipeline: STAGES elastic slots, operands in slot 0, compare result from slot 1 on.
// Define TRAP_CAUSE_EN to carry the per-TO hit vector to port cause.
module trap_pipe_unit
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int XLEN        = 32,
  parameter int STAGES      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [RS_ID_WIDTH-1:0] rs_id_in,
  input  logic [XLEN-1:0]        op1,
  input  logic [XLEN-1:0]        op2,
  input  trap_ctrl_t             control,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic                   trap
`ifdef TRAP_CAUSE_EN
  ,
  output logic [0:TRAP_NUM_TO-1] cause
`endif
);

  logic [STAGES-1:0]      valid_q;
  logic [STAGES-1:0]      valid_d;
  logic [STAGES-1:0]      en;
  logic [RS_ID_WIDTH-1:0] rs_id_q [STAGES];
  logic [RS_ID_WIDTH-1:0] rs_id_d [STAGES];
  logic [XLEN-1:0]        op1_q;
  logic [XLEN-1:0]        op1_d;
  logic [XLEN-1:0]        op2_q;
  logic [XLEN-1:0]        op2_d;
  trap_ctrl_t             ctrl_q;
  trap_ctrl_t             ctrl_d;
  logic [STAGES-1:1]      trap_q;
  logic [STAGES-1:1]      trap_d;
  logic [0:TRAP_NUM_TO-1] hit;
`ifdef TRAP_CAUSE_EN
  logic [0:TRAP_NUM_TO-1] hit_q [1:STAGES-1];
  logic [0:TRAP_NUM_TO-1] hit_d [1:STAGES-1];
`endif

  trap_compare #(
    .XLEN    (XLEN)
  ) u_compare (
    .op1     (op1_q),
    .op2     (op2_q),
    .control (ctrl_q),
    .hit     (hit)
  );

  // A slot may load when it is empty or the slot downstream of it is moving.
  always_comb begin
    en[STAGES-1] = ~valid_q[STAGES-1] | output_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      en[i] = ~valid_q[i] | en[i+1];
    end
  end

  assign input_ready = en[0] & ~flush;

  always_comb begin
    valid_d = valid_q;
    rs_id_d = rs_id_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    ctrl_d  = ctrl_q;
    trap_d  = trap_q;
`ifdef TRAP_CAUSE_EN
    hit_d   = hit_q;
`endif

    if (en[0]) begin
      valid_d[0] = input_valid;
      rs_id_d[0] = rs_id_in;
      op1_d      = op1;
      op2_d      = op2;
      ctrl_d     = control;
    end

    if (en[1]) begin
      valid_d[1] = valid_q[0];
      rs_id_d[1] = rs_id_q[0];
      trap_d[1]  = |hit;
`ifdef TRAP_CAUSE_EN
      hit_d[1]   = hit;
`endif
    end

    for (int i = 2; i < STAGES; i++) begin
      if (en[i]) begin
        valid_d[i] = valid_q[i-1];
        rs_id_d[i] = rs_id_q[i-1];
        trap_d[i]  = trap_q[i-1];
`ifdef TRAP_CAUSE_EN
        hit_d[i]   = hit_q[i-1];
`endif
      end
    end

    // Flush wins over any handshake; payloads left behind are don't-care.
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      ctrl_q  <= '0;
      trap_q  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        rs_id_q[i] <= '0;
      end
`ifdef TRAP_CAUSE_EN
      for (int i = 1; i < STAGES; i++) begin
        hit_q[i] <= '0;
      end
`endif
    end else begin
      valid_q <= valid_d;
      rs_id_q <= rs_id_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      ctrl_q  <= ctrl_d;
      trap_q  <= trap_d;
`ifdef TRAP_CAUSE_EN
      hit_q   <= hit_d;
`endif
    end
  end

  assign output_valid = valid_q[STAGES-1];
  assign rs_id_out    = rs_id_q[STAGES-1];
  assign trap         = trap_q[STAGES-1];
`ifdef TRAP_CAUSE_EN
  assign cause        = hit_q[STAGES-1];
`endif

endmodule

// File: tb/tb_trap_pipe_unit.sv
// Scoreboard bench for trap_pipe_unit (XLEN=64, STAGES=4) with a word-level trap reference model.
module tb_trap_pipe_unit;
  import ppc_types::*;

  localparam int RSW = 5;
  localparam int XL  = 64;
  localparam int ST  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           input_valid;
  logic           input_ready;
  logic [RSW-1:0] rs_id_in;
  logic [XL-1:0]  op1;
  logic [XL-1:0]  op2;
  trap_ctrl_t     control;
  logic           output_valid;
  logic           output_ready;
  logic [RSW-1:0] rs_id_out;
  logic           trap;
`ifdef TRAP_CAUSE_EN
  logic [0:4]     cause;
`endif

  typedef struct {
    logic [RSW-1:0] id;
    logic           trap;
    logic [0:4]     hit;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;
  logic last_acc = 1'b0;

  trap_pipe_unit #(
    .RS_ID_WIDTH (RSW),
    .XLEN        (XL),
    .STAGES      (ST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .rs_id_in     (rs_id_in),
    .op1          (op1),
    .op2          (op2),
    .control      (control),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .rs_id_out    (rs_id_out),
    .trap         (trap)
`ifdef TRAP_CAUSE_EN
    ,
    .cause        (cause)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Trap conditions straight from the architectural definition of tw/td.
  function automatic logic [0:4] ref_hit(logic [63:0] a, logic [63:0] b, trap_ctrl_t c);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              wa, wb;
    logic [0:4]      h;
    if (c.dword) begin
      sa = a; sb = b; ua = a; ub = b;
    end else begin
      wa = a[31:0]; wb = b[31:0];
      sa = wa; sb = wb;
      ua = {32'd0, a[31:0]}; ub = {32'd0, b[31:0]};
    end
    h[0] = c.to[0] && (sa < sb);
    h[1] = c.to[1] && (sa > sb);
    h[2] = c.to[2] && (ua == ub);
    h[3] = c.to[3] && (ua < ub);
    h[4] = c.to[4] && (ua > ub);
    return h;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: sample the input handshake mid-cycle, push its expectation after the edge.
  task automatic step();
    logic a, f, r;
    exp_t e;
    @(negedge clk);
    a = (input_valid === 1'b1) && (input_ready === 1'b1);
    f = flush;
    r = rst;
    e.id   = rs_id_in;
    e.hit  = ref_hit(op1, op2, control);
    e.trap = |e.hit;
    last_acc = a;
    if (a) acc_cyc = cyc;
    @(posedge clk);
    #1;
    if (r || f) q.delete();
    else if (a) q.push_back(e);
  endtask

  task automatic set_op(input logic [RSW-1:0] id, input logic [63:0] a, input logic [63:0] b,
                        input logic [0:4] to, input logic dw);
    input_valid   = 1'b1;
    rs_id_in      = id;
    op1           = a;
    op2           = b;
    control.to    = to;
    control.dword = dw;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (output_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  // Output monitor: every output handshake pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (output_valid === 1'b1 && output_ready === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out actual id=%0d required no output", rs_id_out);
      end else begin
        e = q.pop_front();
        chk("sb_id", rs_id_out, e.id);
        chk("sb_trap", trap, e.trap);
`ifdef TRAP_CAUSE_EN
        chk("sb_cause", cause, e.hit);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         accepted;
    logic       s_vld, s_trap;
    logic [4:0] s_id;

    rst = 1'b1; flush = 1'b0; input_valid = 1'b0; output_ready = 1'b1;
    rs_id_in = '0; op1 = '0; op2 = '0; control = '0;
    step(); step();
    chk("rst_valid", output_valid, 0);
    chk("rst_id", rs_id_out, 0);
    chk("rst_trap", trap, 0);
`ifdef TRAP_CAUSE_EN
    chk("rst_cause", cause, 0);
`endif
    rst = 1'b0;
    #1 chk("rst_ready", input_ready, 1);

    // Signed -1 < 1 on the low word; latency check on an empty pipe.
    set_op(5'd1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'b10000, 1'b0);
    step();
    chk("accept_first", last_acc, 1);
    input_valid = 1'b0;
    wait_out();
    chk("latency", cyc - acc_cyc, ST);
    chk("trap_lt_signed", trap, 1);
    set_op(5'd2, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'b00010, 1'b0);
    step();
    set_op(5'd3, 64'h0000_0001_0000_0000, 64'd0, 5'b00100, 1'b0);
    step();
    set_op(5'd4, 64'h0000_0001_0000_0000, 64'd0, 5'b00100, 1'b1);
    step();
    input_valid = 1'b0;
    repeat (8) step();

    // Random traffic with random backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      input_valid   = ($urandom_range(0, 3) != 0);
      output_ready  = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 29) == 0);
      rs_id_in      = RSW'($urandom);
      op1           = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: op2 = op1;
        1: op2 = {$urandom, op1[31:0]};
        2: op2 = {op1[63:32], $urandom};
        default: op2 = {$urandom, $urandom};
      endcase
      control.to    = 5'($urandom);
      control.dword = 1'($urandom);
      step();
    end
    flush = 1'b0; input_valid = 1'b0; output_ready = 1'b1;
    repeat (10) step();

    // Backpressure: four slots fill, then input stalls and outputs hold.
    output_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      set_op(5'(10 + i), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'($urandom));
      step();
      accepted += int'(last_acc);
    end
    chk("bp_accepted", accepted, 4);
    set_op(5'd16, 64'd0, 64'd0, 5'b00100, 1'b0);
    #1 chk("bp_ready_low", input_ready, 0);
    s_vld = output_valid; s_id = rs_id_out; s_trap = trap;
    chk("bp_head_id", s_id, 10);
    repeat (3) step();
    chk("bp_stable_vld", output_valid, s_vld);
    chk("bp_stable_id", rs_id_out, s_id);
    chk("bp_stable_trap", trap, s_trap);
    input_valid = 1'b0;
    output_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_vld", output_valid, 1);
      chk("drain_id", rs_id_out, 10 + k);
      step();
    end
    repeat (4) step();

    // Flush with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      set_op(5'(17 + i), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'b0);
      step();
    end
    flush = 1'b1;
    set_op(5'd20, 64'd7, 64'd7, 5'b00100, 1'b0);
    step();
    chk("flush_no_accept", last_acc, 0);
    flush = 1'b0;
    input_valid = 1'b0;
    chk("flush_clears", output_valid, 0);
    repeat (3) begin
      step();
      chk("flush_stays_empty", output_valid, 0);
    end
    set_op(5'd21, 64'd3, 64'd9, 5'b01010, 1'b0);
    step();
    input_valid = 1'b0;
    wait_out();
    chk("flush_latency", cyc - acc_cyc, ST);
    chk("flush_next_id", rs_id_out, 21);
    repeat (4) step();

    // Reset mid-stream.
    for (int i = 0; i < 6; i++) begin
      set_op(5'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'($urandom));
      step();
    end
    rst = 1'b1;
    step();
    chk("midrst_valid", output_valid, 0);
    chk("midrst_id", rs_id_out, 0);
    chk("midrst_trap", trap, 0);
`ifdef TRAP_CAUSE_EN
    chk("midrst_cause", cause, 0);
`endif
    rst = 1'b0;
    input_valid = 1'b0;
    step();
    chk("postrst_valid", output_valid, 0);

    set_op(5'd22, 64'd5, 64'd5, 5'b00111, 1'b0);
    step();
    input_valid = 1'b0;
    wait_out();
    chk("eq_trap", trap, 1);
`ifdef TRAP_CAUSE_EN
    chk("eq_cause", cause, 5'b00100);
`endif
    repeat (8) step();
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
